multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Multi-cycle control FSM for the RV32I core; sequences fetch, decode, execute, memory and writeback around the shared ALU, register file and single unified memory port.
- Consumes the instruction register and branch-compare result; drives register/PC/IR write enables, mux selects, ALU mode and the memory request handshake.
- Adds a memory-wait timeout and a sticky trap on illegal opcode or timeout.

Parameters:
- MEM_TIMEOUT, 255, maximum cycles mem_req may wait for mem_ready before trap; legal range 1..65535.
- TW, 16, width of the wait counter; must satisfy 2^TW > MEM_TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  32  current IR contents; opcode is instr[6:0].
- mem_ready  input  1  memory completes the request this cycle.
- branch_taken  input  1  ALU compare result, valid in BRANCH state.
- mem_req  output  1  memory request; held until the mem_ready cycle.
- mem_we  output  1  write qualifier for mem_req.
- addr_src  output  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_write  output  1  load IR from memory read data.
- pc_write  output  1  update PC.
- reg_write  output  1  register-file write enable.
- alu_src_a  output  1  0 = PC, 1 = rs1.
- alu_src_b  output  2  00 = rs2, 01 = immediate, 10 = constant 4.
- alu_mode  output  2  00 = force ADD, 01 = branch compare by funct3, 10 = decode by funct3/funct7.
- result_src  output  2  00 = ALU result, 01 = memory data, 10 = PC+4.
- retire  output  1  one-cycle pulse when an instruction completes.
- trap  output  1  sticky error flag; cleared only by rst.
- trap_cause  output  2  00 = none, 01 = illegal opcode, 10 = memory timeout.

Behaviour:
- Reset (rst high at a clock edge):
  - State goes to FETCH and the wait counter clears.
  - trap and trap_cause go to 0.
  - All outputs are 0 in the reset cycle; rst overrides any in-flight memory request.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEMADDR, MEMREAD, MEMWRITE, LOADWB, ALUWB, BRANCH, TRAP. Outputs are Moore-decoded from state.
- FETCH:
  - Drives mem_req=1, addr_src=0, alu_src_a=0, alu_src_b=10, alu_mode=00.
  - On mem_ready: ir_write=1, pc_write=1, go to DECODE.
  - Otherwise stay in FETCH.
- DECODE: computes branch target (alu_src_a=0, alu_src_b=01, alu_mode=00), then dispatches on opcode:
  - 0110011 -> EXEC_R.
  - 0010011 -> EXEC_I.
  - 0000011 or 0100011 -> MEMADDR.
  - 1100011 -> BRANCH.
  - Any other opcode -> TRAP with cause 01.
- EXEC_R: alu_src_a=1, alu_src_b=00, alu_mode=10; next state ALUWB.
- EXEC_I: alu_src_a=1, alu_src_b=01, alu_mode=10; next state ALUWB.
- ALUWB: reg_write=1, result_src=00, retire=1; next state FETCH.
- MEMADDR: alu_src_a=1, alu_src_b=01, alu_mode=00; next state MEMREAD for a load, MEMWRITE for a store.
- MEMREAD: mem_req=1, addr_src=1, mem_we=0; on mem_ready go to LOADWB.
- LOADWB: reg_write=1, result_src=01, retire=1; next state FETCH.
- MEMWRITE: mem_req=1, mem_we=1, addr_src=1; on mem_ready: retire=1, go to FETCH.
- BRANCH:
  - alu_src_a=1, alu_src_b=00, alu_mode=01.
  - pc_write = branch_taken, selecting the latched target.
  - retire=1; next state FETCH.
- Latency (cycles, zero-wait memory):
  - R/I-type: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Each wait cycle adds 1.
- Wait counter:
  - Clears on entry to any mem_req state.
  - Increments each cycle mem_req=1 and mem_ready=0, saturating at MEM_TIMEOUT.
  - If the counter equals MEM_TIMEOUT and mem_ready=0: go to TRAP with cause 10; mem_req drops the next cycle.
  - mem_ready arriving on the timeout cycle wins: the access completes and no trap is raised.
- TRAP:
  - Absorbing state; all enables and retire are 0, trap=1, trap_cause held.
  - Only rst exits.
- Output registers: trap and trap_cause are registered; all other outputs are combinational from state and inputs.

Test Plan:
- rst high for 2 cycles, then low with mem_ready=1 and instr=0x002081B3 (add x3,x1,x2) -> states FETCH, DECODE, EXEC_R, ALUWB; reg_write=1 only in ALUWB; retire pulse on cycle 4; alu_mode=10 in EXEC_R.
- Load 0x0000A183 with mem_ready low for 3 cycles in MEMREAD -> mem_req held 4 cycles with addr_src=1; LOADWB result_src=01; retire on cycle 8.
- Branch 0x00208463 with branch_taken=1, then again with branch_taken=0 -> pc_write=1 in BRANCH for the first, 0 for the second; both retire after 3 cycles.
- instr=0x0000007F after fetch -> TRAP after DECODE; trap=1, trap_cause=01; no reg_write or pc_write afterwards; rst returns state to FETCH with trap=0.
- MEM_TIMEOUT=4 and mem_ready held 0 in FETCH -> trap_cause=10 on the cycle after the 4th wait; repeat with mem_ready=1 exactly on the timeout cycle -> no trap, DECODE entered.
- rst asserted mid-MEMWRITE with mem_req=1 -> next cycle mem_req=0, state FETCH, no retire.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multi-cycle RV32I control FSM with memory-wait timeout and sticky trap
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TW          = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic        mem_req,
  output logic        mem_we,
  output logic        addr_src,
  output logic        ir_write,
  output logic        pc_write,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_mode,
  output logic [1:0]  result_src,
  output logic        retire,
  output logic        trap,
  output logic [1:0]  trap_cause
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEMADDR, S_MEMREAD,
    S_MEMWRITE, S_LOADWB, S_ALUWB, S_BRANCH, S_TRAP
  } state_t;

  localparam logic [TW-1:0] WAIT_MAX = TW'(MEM_TIMEOUT);

  state_t        state, state_next;
  logic [TW-1:0] wait_cnt;
  logic          trap_q;
  logic [1:0]    cause_q, cause_next;
  logic          mem_state, timeout;
  logic [6:0]    opcode;
  logic          unused_instr;

  assign opcode       = instr[6:0];
  assign unused_instr = ^instr[31:7];
  assign mem_state    = (state == S_FETCH) || (state == S_MEMREAD) || (state == S_MEMWRITE);
  // mem_ready on the timeout cycle still completes the access
  assign timeout      = mem_state && !mem_ready && (wait_cnt == WAIT_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      wait_cnt <= '0;
      trap_q   <= 1'b0;
      cause_q  <= 2'b00;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= '0;
      else if (mem_state && !mem_ready && wait_cnt != WAIT_MAX)
        wait_cnt <= wait_cnt + TW'(1);
      if (state != S_TRAP && state_next == S_TRAP) begin
        trap_q  <= 1'b1;
        cause_q <= cause_next;
      end
    end
  end

  always_comb begin
    state_next = state;
    cause_next = 2'b00;
    case (state)
      S_FETCH: begin
        if (mem_ready) state_next = S_DECODE;
        else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_DECODE: begin
        case (opcode)
          7'b0110011:             state_next = S_EXEC_R;
          7'b0010011:             state_next = S_EXEC_I;
          7'b0000011, 7'b0100011: state_next = S_MEMADDR;
          7'b1100011:             state_next = S_BRANCH;
          default: begin
            state_next = S_TRAP;
            cause_next = 2'b01;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_next = S_ALUWB;
      S_MEMADDR: state_next = opcode[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD, S_MEMWRITE: begin
        if (mem_ready) state_next = (state == S_MEMREAD) ? S_LOADWB : S_FETCH;
        else if (timeout) begin
          state_next = S_TRAP;
          cause_next = 2'b10;
        end
      end
      S_LOADWB, S_ALUWB, S_BRANCH: state_next = S_FETCH;
      S_TRAP:  state_next = S_TRAP;
      default: state_next = S_FETCH;
    endcase
  end

  // Reset forces every output low, including a pending request or trap flag
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    addr_src   = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_mode   = 2'b00;
    result_src = 2'b00;
    retire     = 1'b0;
    if (!rst) begin
      case (state)
        S_FETCH: begin
          mem_req   = 1'b1;
          alu_src_b = 2'b10;
          ir_write  = mem_ready;
          pc_write  = mem_ready;
        end
        S_DECODE: alu_src_b = 2'b01;
        S_EXEC_R: begin
          alu_src_a = 1'b1;
          alu_mode  = 2'b10;
        end
        S_EXEC_I: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
          alu_mode  = 2'b10;
        end
        S_MEMADDR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b01;
        end
        S_MEMREAD: begin
          mem_req  = 1'b1;
          addr_src = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req  = 1'b1;
          mem_we   = 1'b1;
          addr_src = 1'b1;
          retire   = mem_ready;
        end
        S_LOADWB: begin
          reg_write  = 1'b1;
          result_src = 2'b01;
          retire     = 1'b1;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a = 1'b1;
          alu_mode  = 2'b01;
          pc_write  = branch_taken;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign trap       = trap_q & ~rst;
  assign trap_cause = rst ? 2'b00 : cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - scoreboard bench for multicycle_ctrl with a per-cycle instruction model
module tb_multicycle_ctrl;

  localparam int MT = 4;
  localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BR = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = 32'h0;
  logic        mem_ready = 1'b0;
  logic        branch_taken = 1'b0;
  logic        mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, alu_src_a, retire, trap;
  logic [1:0]  alu_src_b, alu_mode, result_src, trap_cause;

  multicycle_ctrl #(.MEM_TIMEOUT(MT), .TW(16)) dut (
    .clk(clk), .rst(rst), .instr(instr), .mem_ready(mem_ready), .branch_taken(branch_taken),
    .mem_req(mem_req), .mem_we(mem_we), .addr_src(addr_src), .ir_write(ir_write),
    .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_mode(alu_mode), .result_src(result_src), .retire(retire), .trap(trap),
    .trap_cause(trap_cause)
  );

  always #5 clk = ~clk;

  logic [16:0] expq[$];
  int n_chk = 0, n_fail = 0;
  int exp_retires = 0, dut_retires = 0;
  logic       tr = 1'b0;
  logic [1:0] tc = 2'b00;

  // Expected outputs of one cycle, with the model's current trap flag/cause appended
  function automatic logic [16:0] ov(input logic mreq, mwe, asrc, irw, pcw, rw, sa,
                                     input logic [1:0] sb, md, rs, input logic ret);
    return {mreq, mwe, asrc, irw, pcw, rw, sa, sb, md, rs, ret, tr, tc};
  endfunction

  task automatic cyc(input logic r, input logic rdy, input logic bt, input logic [16:0] e);
    @(posedge clk);
    #1;
    rst = r;
    mem_ready = rdy;
    branch_taken = bt;
    expq.push_back(e);
    exp_retires += int'(e[3]);
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      logic [16:0] e, got;
      e = expq.pop_front();
      got = {mem_req, mem_we, addr_src, ir_write, pc_write, reg_write, alu_src_a,
             alu_src_b, alu_mode, result_src, retire, trap, trap_cause};
      dut_retires += int'(retire);
      n_chk++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL cycle_outputs t=%0t got=%05h expected=%05h", $time, got, e);
      end
    end
  end

  task automatic do_reset(input int n);
    tr = 1'b0;
    tc = 2'b00;
    for (int i = 0; i < n; i++)
      cyc(1'b1, 1'($urandom), 1'($urandom), 17'h0);
  endtask

  // kind: 0 fetch, 1 load read, 2 store write; waits > MT means memory never answers
  task automatic mem_phase(input int kind, input int waits, output logic trapped);
    int n;
    logic rdy;
    trapped = 1'b0;
    n = (waits > MT) ? MT + 1 : waits + 1;
    for (int i = 0; i < n; i++) begin
      rdy = (i == waits);
      case (kind)
        0:       cyc(1'b0, rdy, 1'($urandom), ov(1, 0, 0, rdy, rdy, 0, 0, 2'b10, 2'b00, 2'b00, 0));
        1:       cyc(1'b0, rdy, 1'($urandom), ov(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
        default: cyc(1'b0, rdy, 1'($urandom), ov(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, rdy));
      endcase
    end
    if (waits > MT) begin
      tr = 1'b1;
      tc = 2'b10;
      trapped = 1'b1;
    end
  endtask

  task automatic trap_idle(input int n);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 1'($urandom), 1'($urandom), ov(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
  endtask

  task automatic run_instr(input logic [31:0] iw, input int kind, input int wf, input int wm,
                           input logic taken);
    logic trapped;
    instr = iw;
    mem_phase(0, wf, trapped);
    if (trapped) return;
    cyc(1'b0, 1'($urandom), 1'($urandom), ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    case (kind)
      K_R, K_I: begin
        cyc(1'b0, 1'($urandom), 1'($urandom),
            ov(0, 0, 0, 0, 0, 0, 1, (kind == K_I) ? 2'b01 : 2'b00, 2'b10, 2'b00, 0));
        cyc(1'b0, 1'($urandom), 1'($urandom), ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1));
      end
      K_LD, K_ST: begin
        cyc(1'b0, 1'($urandom), 1'($urandom), ov(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0));
        mem_phase((kind == K_LD) ? 1 : 2, wm, trapped);
        if (kind == K_LD && !trapped)
          cyc(1'b0, 1'($urandom), 1'($urandom), ov(0, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b01, 1));
      end
      K_BR:
        cyc(1'b0, 1'($urandom), taken, ov(0, 0, 0, 0, taken, 0, 1, 2'b00, 2'b01, 2'b00, 1));
      default: begin
        tr = 1'b1;
        tc = 2'b01;
      end
    endcase
  endtask

  function automatic logic [31:0] rand_instr(input int kind);
    logic [31:0] r;
    logic [6:0]  op;
    r = $urandom();
    case (kind)
      K_R:  op = 7'b0110011;
      K_I:  op = 7'b0010011;
      K_LD: op = 7'b0000011;
      K_ST: op = 7'b0100011;
      K_BR: op = 7'b1100011;
      default: begin
        op = 7'($urandom);
        while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
               op == 7'b0100011 || op == 7'b1100011)
          op = 7'($urandom);
      end
    endcase
    return {r[31:7], op};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, wf, wm;
    logic dummy;
    do_reset(2);
    run_instr(32'h002081B3, K_R, 0, 0, 1'b0);
    run_instr(32'h0000A183, K_LD, 0, 3, 1'b0);
    run_instr(32'h00208463, K_BR, 0, 0, 1'b1);
    run_instr(32'h00208463, K_BR, 0, 0, 1'b0);
    run_instr(32'h0000007F, K_ILL, 0, 0, 1'b0);
    trap_idle(4);
    do_reset(2);
    run_instr(32'h002081B3, K_R, MT + 1, 0, 1'b0);
    trap_idle(3);
    do_reset(1);
    run_instr(32'h002081B3, K_R, MT, 0, 1'b0);
    run_instr(rand_instr(K_ST), K_ST, 0, MT + 1, 1'b0);
    trap_idle(2);
    do_reset(1);
    instr = rand_instr(K_ST);
    mem_phase(0, 0, dummy);
    cyc(1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 0));
    cyc(1'b0, 1'b0, 1'b0, ov(0, 0, 0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, 0));
    cyc(1'b0, 1'b0, 1'b0, ov(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    cyc(1'b0, 1'b0, 1'b0, ov(1, 1, 1, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 0));
    do_reset(1);
    run_instr(rand_instr(K_ST), K_ST, 1, MT, 1'b0);
    for (int n = 0; n < 300; n++) begin
      kind = ($urandom_range(0, 24) == 0) ? K_ILL : $urandom_range(0, 4);
      wf = ($urandom_range(0, 30) == 0) ? MT + 1 : $urandom_range(0, MT);
      wm = ($urandom_range(0, 30) == 0) ? MT + 1 : $urandom_range(0, MT);
      run_instr(rand_instr(kind), kind, wf, wm, 1'($urandom));
      if (tr) begin
        trap_idle($urandom_range(1, 4));
        do_reset($urandom_range(1, 2));
      end
    end
    repeat (2) @(posedge clk);
    n_chk++;
    if (dut_retires != exp_retires) begin
      n_fail++;
      $display("FAIL retire_count got=%0d expected=%0d", dut_retires, exp_retires);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
